// File: rtl/ahb_master_cmd_fifo.sv
// AHB master command FIFO: FWFT head, optional replay window for RETRY/SPLIT.
// Define AHB_CMD_FIFO_REPLAY_EN to enable the tail_back rewind window.
module ahb_master_cmd_fifo #(
  parameter int DATA_W     = 67,
  parameter int DEPTH_LOG2 = 5,
  parameter int HOLD       = 17
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [DATA_W-1:0]     datain,
  input  logic                  fifo_writen,
  input  logic                  fifo_readen,
  input  logic                  tail_back,
  input  logic [4:0]            back_length,
  output logic [DATA_W-1:0]     dataout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic [2:0]            err_flags
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2 ** DEPTH_LOG2);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rel_ptr;
  logic [PW-1:0]     rd_nxt;
  logic [2:0]        err_q;
  logic              do_wr;
  logic              do_rd;
  logic              do_rw;
  logic              clamp;

  assign empty     = rd_ptr == wr_ptr;
  assign full      = (wr_ptr - rel_ptr) == DEPTH;
  assign level     = wr_ptr - rd_ptr;
  assign dataout   = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign err_flags = err_q;
  assign do_wr     = fifo_writen & ~full;
  assign do_rd     = fifo_readen & ~do_rw & ~empty;

`ifdef AHB_CMD_FIFO_REPLAY_EN
  logic [PW-1:0] held;
  logic [PW-1:0] back_ext;
  logic [PW-1:0] rw_amt;

  assign held     = rd_ptr - rel_ptr;
  assign back_ext = PW'(back_length);
  assign do_rw    = tail_back;
  assign clamp    = back_ext > held;
  assign rw_amt   = clamp ? held : back_ext;

  // Release the oldest retained entry once the window is full
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      rel_ptr <= '0;
    else if (do_rd && held == PW'(HOLD))
      rel_ptr <= rel_ptr + 1'b1;
  end
`else
  logic unused_replay;

  assign unused_replay = ^{tail_back, back_length};
  assign do_rw         = 1'b0;
  assign clamp         = 1'b0;
  assign rel_ptr       = rd_ptr;
`endif

  // Read pointer: rewind takes priority over pop
  always_comb begin
    rd_nxt = rd_ptr;
`ifdef AHB_CMD_FIFO_REPLAY_EN
    if (do_rw)
      rd_nxt = rd_ptr - rw_amt;
    else if (do_rd)
      rd_nxt = rd_ptr + 1'b1;
`else
    if (do_rd)
      rd_nxt = rd_ptr + 1'b1;
`endif
  end

  // Pointer and sticky error registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      err_q  <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (fifo_writen && full)
        err_q[0] <= 1'b1;
      if (fifo_readen && !do_rw && empty)
        err_q[1] <= 1'b1;
      if (do_rw && clamp)
        err_q[2] <= 1'b1;
    end
  end

  // Entry storage, not reset
  always_ff @(posedge HCLK) begin
    if (do_wr)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= datain;
  end

endmodule
